// File: rtl/fb_writer.sv
// Framebuffer write sink: turns the raster pixel stream into linear memory writes through a 2-entry FIFO
// and pulses tile_done every 256 retired pixels. Define FB_SKIP_BACKGROUND_EN to drop color-0 pixels.
module fb_writer #(
  parameter int SCREEN_W          = 1024,
  parameter int SCREEN_H          = 512,
  parameter int ADDR_W            = 19,
  parameter int COLOR_BITS        = 16,
  parameter int COORD_BITS        = 12,
  parameter int TILE_COLUMNS_BITS = 6,
  parameter int TILE_ROWS_BITS    = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vld_in,
  output logic                         rdy_in,
  input  logic [COLOR_BITS-1:0]        color_in,
  // packed coordinate pair: {x, y}, each COORD_BITS wide, integer pixels
  input  logic [2*COORD_BITS-1:0]      pixel_in,
  output logic                         fb_we,
  output logic [ADDR_W-1:0]            fb_addr,
  output logic [COLOR_BITS-1:0]        fb_wdata,
  input  logic                         fb_rdy,
  output logic                         tile_done,
  output logic [TILE_COLUMNS_BITS-1:0] tile_x_out,
  output logic [TILE_ROWS_BITS-1:0]    tile_y_out,
  output logic                         err_range
);

  logic [COORD_BITS-1:0] pix_x;
  logic [COORD_BITS-1:0] pix_y;
  logic                  in_range;
  logic                  keep_in;
  logic [ADDR_W-1:0]     addr_in;

  logic [ADDR_W-1:0]            addr_mem  [0:1];
  logic [COLOR_BITS-1:0]        color_mem [0:1];
  logic                         keep_mem  [0:1];
  logic [TILE_COLUMNS_BITS-1:0] tx_mem    [0:1];
  logic [TILE_ROWS_BITS-1:0]    ty_mem    [0:1];

  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       head_reg;
  logic       tail;
  logic       run_reg;
  logic [7:0] tile_cnt_reg;
  logic       tile_done_reg;
  logic [TILE_COLUMNS_BITS-1:0] tile_x_reg;
  logic [TILE_ROWS_BITS-1:0]    tile_y_reg;
  logic       err_reg;

  logic       has_data;
  logic       head_keep;
  logic       push;
  logic       pop;
  logic [1:0] wr_en;

  assign pix_x = pixel_in[2*COORD_BITS-1:COORD_BITS];
  assign pix_y = pixel_in[COORD_BITS-1:0];

  assign in_range = (32'(pix_x) < 32'(SCREEN_W)) && (32'(pix_y) < 32'(SCREEN_H));
  assign addr_in  = ADDR_W'(pix_y) * ADDR_W'(SCREEN_W) + ADDR_W'(pix_x);

`ifdef FB_SKIP_BACKGROUND_EN
  // background (color 0) pixels retire without touching memory
  assign keep_in = in_range && (color_in != '0);
`else
  assign keep_in = in_range;
`endif

  assign has_data  = (count_reg != 2'd0);
  assign head_keep = keep_mem[head_reg];
  assign tail      = head_reg ^ count_reg[0];

  assign rdy_in = run_reg && (count_reg < 2'd2);
  assign push   = vld_in && rdy_in;
  assign fb_we  = has_data && head_keep;
  assign pop    = (fb_we && fb_rdy) || (has_data && !head_keep);

  assign fb_addr  = has_data ? addr_mem[head_reg]  : '0;
  assign fb_wdata = has_data ? color_mem[head_reg] : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (tail == 1'(gi));
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        addr_mem[i]  <= '0;
        color_mem[i] <= '0;
        keep_mem[i]  <= 1'b0;
        tx_mem[i]    <= '0;
        ty_mem[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          addr_mem[i]  <= addr_in;
          color_mem[i] <= color_in;
          keep_mem[i]  <= keep_in;
          tx_mem[i]    <= pix_x[TILE_COLUMNS_BITS+3:4];
          ty_mem[i]    <= pix_y[TILE_ROWS_BITS+3:4];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
      run_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      run_reg   <= 1'b1;
      if (pop) head_reg <= ~head_reg;
      if (push && !in_range) err_reg <= 1'b1;
    end
  end

  // tile counter wraps on its own; the wrap edge captures the head tile for the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt_reg  <= 8'd0;
      tile_done_reg <= 1'b0;
      tile_x_reg    <= '0;
      tile_y_reg    <= '0;
    end else begin
      tile_done_reg <= pop && (tile_cnt_reg == 8'hFF);
      if (pop) begin
        tile_cnt_reg <= tile_cnt_reg + 8'd1;
        if (tile_cnt_reg == 8'hFF) begin
          tile_x_reg <= tx_mem[head_reg];
          tile_y_reg <= ty_mem[head_reg];
        end
      end
    end
  end

  assign tile_done  = tile_done_reg;
  assign tile_x_out = tile_x_reg;
  assign tile_y_out = tile_y_reg;
  assign err_range  = err_reg;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: reset, latency, backpressure, reset mid-burst, tile pulses,
// out-of-range and background pixels, all checked against hand-computed values.
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld_in = 1'b0;
  logic        rdy_in;
  logic [15:0] color_in = '0;
  logic [23:0] pixel_in = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [15:0] fb_wdata;
  logic        fb_rdy = 1'b0;
  logic        tile_done;
  logic [5:0]  tile_x_out;
  logic [4:0]  tile_y_out;
  logic        err_range;

  fb_writer dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
    .color_in(color_in), .pixel_in(pixel_in),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdy(fb_rdy),
    .tile_done(tile_done), .tile_x_out(tile_x_out), .tile_y_out(tile_y_out),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // write / tile_done monitor, sampled mid-cycle
  int cyc = 0, n_wr = 0, n_done = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [5:0] done_tx = '0;
  logic [4:0] done_ty = '0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clk) begin
    cyc++;
    if (fb_we && fb_rdy) begin
      n_wr++;
      last_wr_cyc = cyc;
      wr_addr_q.push_back(32'(fb_addr));
      wr_data_q.push_back(32'(fb_wdata));
      $display("wr   addr=%0d data=%0d", fb_addr, fb_wdata);
    end
    if (tile_done) begin
      n_done++;
      done_cyc = cyc;
      done_tx = tile_x_out;
      done_ty = tile_y_out;
      $display("tile done x=%0d y=%0d", tile_x_out, tile_y_out);
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int x, input int y, input int c, output int waited);
    logic acc;
    vld_in   = 1'b1;
    pixel_in = {12'(x), 12'(y)};
    color_in = 16'(c);
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = rdy_in;
      waited++;
      @(posedge clk);
      #1;
    end
    if (!acc) check_val("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    vld_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int w, tot, n0, nd0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rdy_in", 32'(rdy_in), 0);
    check_val("rst_fb_we", 32'(fb_we), 0);
    check_val("rst_fb_addr", 32'(fb_addr), 0);
    check_val("rst_fb_wdata", 32'(fb_wdata), 0);
    check_val("rst_tile_done", 32'(tile_done), 0);
    check_val("rst_tile_x", 32'(tile_x_out), 0);
    check_val("rst_tile_y", 32'(tile_y_out), 0);
    check_val("rst_err", 32'(err_range), 0);
    rst_n = 1'b1;
    check_val("run_not_yet", 32'(rdy_in), 0);
    @(posedge clk);
    #1;
    check_val("run_rdy", 32'(rdy_in), 1);

    // single pixel latency
    fb_rdy = 1'b1;
    send(3, 2, 4, w);
    check_val("single_we", 32'(fb_we), 1);
    check_val("single_addr", 32'(fb_addr), 2051);
    check_val("single_data", 32'(fb_wdata), 4);
    check_val("single_rdy", 32'(rdy_in), 1);
    idle(2);
    check_val("single_nwr", 32'(n_wr), 1);

    // backpressure: fb_rdy low for 5 cycles
    wr_addr_q.delete();
    wr_data_q.delete();
    n0 = n_wr;
    fb_rdy = 1'b0;
    send(10, 1, 7, w);
    send(11, 1, 8, w);
    check_val("bp_rdy_low", 32'(rdy_in), 0);
    check_val("bp_head_we", 32'(fb_we), 1);
    check_val("bp_head_addr", 32'(fb_addr), 1034);
    pixel_in = {12'd12, 12'd1};
    color_in = 16'd9;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_val("bp_still_full", 32'(rdy_in), 0);
    check_val("bp_no_write", 32'(n_wr - n0), 0);
    fb_rdy = 1'b1;
    send(12, 1, 9, w);
    send(5, 3, 10, w);
    idle(6);
    check_val("bp_nwr", 32'(n_wr - n0), 4);
    if (wr_addr_q.size() == 4) begin
      check_val("bp_a0", wr_addr_q[0], 1034);
      check_val("bp_d0", wr_data_q[0], 7);
      check_val("bp_a1", wr_addr_q[1], 1035);
      check_val("bp_d1", wr_data_q[1], 8);
      check_val("bp_a2", wr_addr_q[2], 1036);
      check_val("bp_d2", wr_data_q[2], 9);
      check_val("bp_a3", wr_addr_q[3], 3077);
      check_val("bp_d3", wr_data_q[3], 10);
    end

    // reset with a full FIFO
    fb_rdy = 1'b0;
    send(1, 1, 1, w);
    send(2, 1, 2, w);
    vld_in = 1'b0;
    check_val("mid_full", 32'(rdy_in), 0);
    n0 = n_wr;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_we", 32'(fb_we), 0);
    check_val("mid_rst_rdy", 32'(rdy_in), 0);
    @(posedge clk);
    #1;
    fb_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rdy_back", 32'(rdy_in), 1);
    idle(2);
    check_val("mid_no_write", 32'(n_wr - n0), 0);

    // full tile (1,0) burst at one pixel per cycle
    wr_addr_q.delete();
    wr_data_q.delete();
    n0 = n_wr;
    nd0 = n_done;
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      send(16 + i % 16, i / 16, 1 + i % 16, w);
      tot += w;
    end
    idle(4);
    check_val("tile_cycles", 32'(tot), 256);
    check_val("tile_nwr", 32'(n_wr - n0), 256);
    check_val("tile_ndone", 32'(n_done - nd0), 1);
    check_val("tile_x", 32'(done_tx), 1);
    check_val("tile_y", 32'(done_ty), 0);
    check_val("tile_delay", 32'(done_cyc - last_wr_cyc), 1);
    if (wr_addr_q.size() == 256) begin
      check_val("tile_first_addr", wr_addr_q[0], 16);
      check_val("tile_last_addr", wr_addr_q[255], 15391);
      check_val("tile_last_data", wr_data_q[255], 16);
    end

    // out-of-range pixel counts toward the next tile (2,3)
    check_val("oor_err_before", 32'(err_range), 0);
    n0 = n_wr;
    nd0 = n_done;
    send(1024, 0, 5, w);
    idle(2);
    check_val("oor_no_write", 32'(n_wr - n0), 0);
    check_val("oor_err", 32'(err_range), 1);
    for (int i = 0; i < 255; i++) send(32 + i % 16, 48 + i / 16, 3, w);
    idle(4);
    check_val("oor_nwr", 32'(n_wr - n0), 255);
    check_val("oor_ndone", 32'(n_done - nd0), 1);
    check_val("oor_tile_x", 32'(done_tx), 2);
    check_val("oor_tile_y", 32'(done_ty), 3);
    check_val("oor_err_sticky", 32'(err_range), 1);

    // background pixels in tile (3,1)
    n0 = n_wr;
    nd0 = n_done;
    for (int i = 0; i < 256; i++) send(48 + i % 16, 16 + i / 16, 0, w);
    idle(4);
`ifdef FB_SKIP_BACKGROUND_EN
    check_val("bg_nwr", 32'(n_wr - n0), 0);
`else
    check_val("bg_nwr", 32'(n_wr - n0), 256);
`endif
    check_val("bg_ndone", 32'(n_done - nd0), 1);
    check_val("bg_tile_x", 32'(done_tx), 3);
    check_val("bg_tile_y", 32'(done_ty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
# fb_writer

Pixel sink at the back end of `raster`: consumes the rasterizer's pixel stream (`vld_out`/`rdy_out`, `color_out`, `pixel_out`) and converts each pixel into a linear framebuffer write. A 2-entry buffer decouples the rasterizer from a stalling memory port. A per-tile pixel counter pulses a tile-done event so the frame controller knows when a tile's burst has fully drained to memory.

## Interface
- `SCREEN_W`, default 1024: pixels per row; `TILE_COLUMNS_BITS`=6 gives 64 tiles × 16.
- `SCREEN_H`, default 512: rows; `TILE_ROWS_BITS`=5 gives 32 tiles × 16.
- `ADDR_W`, default 19: framebuffer address width; must satisfy SCREEN_W·SCREEN_H ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vld_in`  in  1  pixel valid; connect to raster `vld_out`.
- `rdy_in`  out  1  ready to accept a pixel; connect to raster `rdy_out`.
- `color_in`  in  `COLOR_BITS`  pixel color.
- `pixel_in`  in  `coord_2d_t`  integer screen coordinates `.x`, `.y` (not fixed-point).
- `fb_we`  out  1  write request.
- `fb_addr`  out  `ADDR_W`  write address, y·SCREEN_W + x.
- `fb_wdata`  out  `COLOR_BITS`  write data.
- `fb_rdy`  in  1  memory accepts the write this cycle when `fb_we & fb_rdy`.
- `tile_done`  out  1  one-cycle pulse: `TILE_AREA` pixels of a tile retired.
- `tile_x_out`  out  `TILE_COLUMNS_BITS`  tile column of the last retired pixel; valid with `tile_done`.
- `tile_y_out`  out  `TILE_ROWS_BITS`  tile row of the last retired pixel; valid with `tile_done`.
- `err_range`  out  1  sticky: a pixel with x ≥ SCREEN_W or y ≥ SCREEN_H was received.

## Operation
- Buffer: 2-entry FIFO of {addr, color, keep, tile_x, tile_y}.
  - Push when `vld_in & rdy_in`.
  - Address is computed at push with a constant-multiply; the result is truncated to `ADDR_W`.
  - `keep` = in-range, AND-ed with the optional background filter (see Configuration).
- Ready and write request:
  - `rdy_in` = `run & (count < 2)`.
  - `run` is a flop that is 0 in reset and sets on the first clock after reset release.
  - `fb_we` = `count != 0 & head.keep`.
- Retire (pop) when `(fb_we & fb_rdy) | (count != 0 & !head.keep)`. Dropped pixels retire in one cycle without asserting `fb_we`.
- Simultaneous push and pop:
  - count 1 → stays 1, FIFO order preserved.
  - count 2 → no push possible (`rdy_in` = 0).
  - count 0 → push only; pop is impossible.
- Tile counter: 8-bit (`TILE_AREA` = 256).
  - Increments on every retire, whether written or dropped.
  - On the retire that brings it to 256, it wraps to 0. The next cycle, `tile_done` = 1 and `tile_x_out`/`tile_y_out` = head tile fields (x>>4, y>>4).
- Out-of-range pixels: `err_range` sets and holds until reset. The pixel is dropped but counted.
- `fb_addr`/`fb_wdata` show the head entry whenever `count != 0`; they are don't-care when `fb_we` = 0.

## Timing
- Reset values:
  - `rdy_in` 0, `fb_we` 0, `fb_addr` 0, `fb_wdata` 0.
  - `tile_done` 0, `tile_x_out` 0, `tile_y_out` 0, `err_range` 0.
  - count 0, tile counter 0, `run` 0.
- Latency: pixel accepted at edge N → `fb_we` high during cycle N+1 (combinational from FIFO head).
- Throughput: 1 pixel/cycle while `fb_rdy` = 1.
- Stall: `fb_rdy` low for 2+ cycles → FIFO fills, `rdy_in` drops the cycle after the second push. It rises the cycle after the first retire.
- `tile_done`: registered, exactly one cycle, the cycle after the 256th retire.
- Reset mid-operation: FIFO contents and tile counter are discarded immediately. No write completes after `rst_n` falls.

## Configuration
- `FB_SKIP_BACKGROUND_EN` defined: pixels with `color_in == 0` get `keep` = 0. They are retired and counted without a memory write, so flush triangles do not overwrite stored pixels.
- Undefined: color-0 pixels are written like any other pixel.

## Test plan
- Single pixel, `fb_rdy` = 1: x=3, y=2, color 4 → next cycle `fb_we` = 1, `fb_addr` = 2051, `fb_wdata` = 4; `rdy_in` stays 1.
- Backpressure: 4 pixels back-to-back, `fb_rdy` = 0 for 5 cycles → `rdy_in` = 0 after 2 pushes. All 4 writes emerge in order once `fb_rdy` = 1, with no loss or duplication.
- Tile burst: 256 pixels covering tile (1,0), x 16–31, y 0–15 → 256 writes. `tile_done` pulses exactly once, one cycle after the last write, with `tile_x_out` = 1, `tile_y_out` = 0.
- Out-of-range: x=1024, y=0 → no `fb_we`, `err_range` = 1 and stays 1. The pixel still counts toward `tile_done`.
- Background filter: 256 color-0 pixels. With `FB_SKIP_BACKGROUND_EN`, zero writes and `tile_done` still pulses. Without it, 256 writes.
- Reset mid-burst: `rst_n` low with count = 2 → `fb_we`, `rdy_in`, count = 0 immediately. After release, `rdy_in` = 1 one cycle later and the next tile counts from 0.
